// File: rtl/fetch_pkg.sv
// Shared widths, PC step and queue entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign empty     = (count_q == '0);
  assign occupancy = count_q;
  // Zero the head while empty so stale storage never leaks onto the outputs.
  assign head      = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // The credit scheme upstream must never let a push land on a full queue without a pop.
  assert property (@(posedge clk) disable iff (reset || flush)
    (push && !pop) |-> (count_q != CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads, buffers responses for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  inst_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pending_pc_q;
  // Set only for the cycle a live response is due; clearing it is how a flush kills it.
  logic              inflight_q;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  credits_used;
  logic              issue;
  logic              queue_empty;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Registered counts only: a pop this cycle does not free a credit until next cycle.
  assign credits_used = occupancy + CNT_W'(inflight_q);
  assign issue        = !reset && !redirect && (credits_used < CNT_W'(QDEPTH));
  assign imem_req     = issue;
  assign inst_addr    = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      inflight_q   <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fetch_pc_q   <= fetch_pc_q + PC_INC;
        pending_pc_q <= fetch_pc_q;
      end
    end
  end

  assign push_entry = '{instr: instr, pc: pending_pc_q};
  assign pop        = out_valid && out_ready && !redirect;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (inflight_q),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (queue_empty),
    .occupancy  (occupancy)
  );

  assign out_valid = !queue_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a scoreboard fed by restart events.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned QD     = 4;

  localparam int D_NONE     = 0;
  localparam int D_REQ      = 1;
  localparam int D_NOREQ    = 2;
  localparam int D_VALID_PC = 3;
  localparam int D_NOVALID  = 4;
  localparam int D_MARK     = 5;
  localparam int D_ISSUES   = 6;
  localparam int D_VALIDS   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_addr;
  logic        imem_req;
  logic [31:0] instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        rst_q;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .imem_req    (imem_req),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Memory answers one cycle after a request; otherwise drives junk.
  always @(posedge clk) begin
    instr <= imem_req ? mem_word(inst_addr) : 32'hBAD0_BAD0;
    rst_q <= reset;
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_next = 32'h0;
  logic [31:0] iss_pc = 32'h0;
  int          errors = 0;
  int          checks = 0;
  int          issue_cnt = 0;
  int          valid_cnt = 0;
  int          issue_base = 0;
  int          valid_base = 0;
  int          dir_kind = D_NONE;
  logic [31:0] dir_val = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: mem_word(exp_next), pc: exp_next});
      exp_next += 32'd4;
    end
  endtask

  // A restart means decode will next see a plain sequential stream from pc.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
    iss_pc   = pc;
    top_up();
  endtask

  always @(negedge clk) begin
    exp_t e;
    case (dir_kind)
      D_REQ: begin
        chk("req_present", imem_req, 1);
        chk("req_addr", inst_addr, dir_val);
      end
      D_NOREQ:    chk("req_absent", imem_req, 0);
      D_VALID_PC: begin
        chk("head_valid", out_valid, 1);
        chk("head_pc", out_pc, dir_val);
      end
      D_NOVALID:  chk("head_absent", out_valid, 0);
      D_MARK: begin
        issue_base = issue_cnt;
        valid_base = valid_cnt;
      end
      D_ISSUES:   chk("issue_count", issue_cnt - issue_base, dir_val);
      D_VALIDS:   chk("valid_count", valid_cnt - valid_base, dir_val);
      default: ;
    endcase

    if (rst_q) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_inst_addr", inst_addr, RST_PC);
    end

    if (reset) begin
      chk("req_in_reset", imem_req, 0);
      restart(RST_PC);
    end else if (redirect) begin
      chk("req_in_redirect", imem_req, 0);
      restart(redirect_pc & 32'hFFFF_FFFC);
    end else begin
      if (imem_req) begin
        chk("issue_addr", inst_addr, iss_pc);
        iss_pc += 32'd4;
        issue_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got pc 0x%08h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          top_up();
        end
      end
    end

    if (out_valid) valid_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    dir_kind = D_NONE;
  endtask

  initial begin
    // Reset release, then first issue, first beat and gap-free streaming.
    step();
    step();
    reset = 1'b0;
    dir_kind = D_REQ;
    dir_val = RST_PC;
    step();
    step();
    dir_kind = D_VALID_PC;
    dir_val = RST_PC;
    step();
    dir_kind = D_MARK;
    repeat (20) step();
    dir_kind = D_VALIDS;
    dir_val = 20;

    // Backpressure: restart at 0 with decode stalled for 10 cycles.
    step();
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    dir_kind = D_MARK;
    repeat (9) step();
    dir_kind = D_VALID_PC;
    dir_val = 32'h0;
    step();
    dir_kind = D_ISSUES;
    dir_val = QD;
    out_ready = 1'b1;
    repeat (8) step();

    // Redirect with a request in flight.
    step();
    redirect = 1'b1;
    redirect_pc = 32'h43;
    dir_kind = D_NOREQ;
    step();
    redirect = 1'b0;
    dir_kind = D_REQ;
    dir_val = 32'h40;
    step();
    dir_kind = D_NOVALID;
    step();
    dir_kind = D_VALID_PC;
    dir_val = 32'h40;
    repeat (5) step();

    // Address wrap.
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    dir_kind = D_REQ;
    dir_val = 32'hFFFF_FFF8;
    step();
    dir_kind = D_REQ;
    dir_val = 32'hFFFF_FFFC;
    step();
    dir_kind = D_REQ;
    dir_val = 32'h0;
    repeat (6) step();

    // Reset with the queue full.
    step();
    out_ready = 1'b0;
    repeat (8) step();
    dir_kind = D_VALID_PC;
    dir_val = 32'h0000_0014;
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    dir_kind = D_REQ;
    dir_val = RST_PC;
    step();
    dir_kind = D_NOVALID;
    step();
    dir_kind = D_VALID_PC;
    dir_val = RST_PC;
    repeat (4) step();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_pc[31:5] = '1;
      reset = ($urandom_range(0, 199) == 0);
    end
    step();
    reset = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
